// File: rtl/palette_fade_ctrl.sv
// Brightness fade sequencer for the background palette path: forwards the pixel index to the
// palette ROM and scales the returned RGB by a frame-stepped level. Optional white flash: PALETTE_FADE_FLASH_EN.
module palette_fade_ctrl #(
  parameter int FRAMES_PER_STEP = 2,
  parameter int STEP            = 2,
  parameter int FLASH_FRAMES    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] pix_index_i,
  input  logic       pix_valid_i,
  input  logic       vsync_pulse_i,
  input  logic       fade_out_req_i,
  input  logic       fade_in_req_i,
  input  logic       flash_req_i,
  output logic [4:0] pal_index_o,
  input  logic [3:0] pal_red_i,
  input  logic [3:0] pal_green_i,
  input  logic [3:0] pal_blue_i,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
  output logic       rgb_valid_o,
  output logic [4:0] level_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int             FCW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FCW-1:0] FC_LAST   = FCW'(FRAMES_PER_STEP - 1);
  localparam logic [5:0]     STEP_W    = 6'(STEP);
  localparam logic [4:0]     LEVEL_MAX = 5'd16;

  typedef enum logic [1:0] {
    ST_DARK,
    ST_FADE_IN,
    ST_FULL,
    ST_FADE_OUT
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     level_q, level_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           done_q, done_d;
  logic [3:0]     red_q, green_q, blue_q;
  logic [3:0]     red_d, green_d, blue_d;
  logic           rgb_valid_q;
  logic           flash_active;

  // Product keeps bits [7:4], so level 16 is identity and level 0 is black.
  function automatic logic [3:0] scale(input logic [3:0] chan, input logic [4:0] lvl);
    return 4'(({5'd0, chan} * {4'd0, lvl}) >> 4);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;

    if ((state_q == ST_FADE_OUT || state_q == ST_FADE_IN) && vsync_pulse_i) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        if (state_q == ST_FADE_OUT) begin
          level_d = (6'(level_q) > STEP_W) ? 5'(6'(level_q) - STEP_W) : 5'd0;
          if (level_d == 5'd0) begin
            state_d = ST_DARK;
            done_d  = 1'b1;
          end
        end else begin
          level_d = ((6'(level_q) + STEP_W) >= 6'(LEVEL_MAX)) ? LEVEL_MAX
                                                              : 5'(6'(level_q) + STEP_W);
          if (level_d == LEVEL_MAX) begin
            state_d = ST_FULL;
            done_d  = 1'b1;
          end
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end

    // Requests act on the post-step state, so a reversal on a step edge keeps the new level.
    if (fade_out_req_i) begin
      if (state_d == ST_FULL || state_d == ST_FADE_IN) begin
        state_d     = ST_FADE_OUT;
        frame_cnt_d = '0;
      end
    end else if (fade_in_req_i) begin
      if (state_d == ST_DARK || state_d == ST_FADE_OUT) begin
        state_d     = ST_FADE_IN;
        frame_cnt_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_DARK;
      level_q     <= 5'd0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
    end
  end

`ifdef PALETTE_FADE_FLASH_EN
  localparam int FLW = $clog2(FLASH_FRAMES + 1);

  logic [FLW-1:0] flash_cnt_q, flash_cnt_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (flash_req_i) begin
      flash_cnt_d = FLW'(FLASH_FRAMES);
    end else if (vsync_pulse_i && flash_cnt_q != '0) begin
      flash_cnt_d = flash_cnt_q - FLW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flash_cnt_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign flash_active = (flash_cnt_q != '0);
`else
  logic unused_flash_req;
  assign unused_flash_req = flash_req_i;
  assign flash_active     = 1'b0;
`endif

  always_comb begin
    red_d   = 4'd0;
    green_d = 4'd0;
    blue_d  = 4'd0;
    if (pix_valid_i) begin
      if (flash_active) begin
        red_d   = 4'hF;
        green_d = 4'hF;
        blue_d  = 4'hF;
      end else begin
        red_d   = scale(pal_red_i, level_q);
        green_d = scale(pal_green_i, level_q);
        blue_d  = scale(pal_blue_i, level_q);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      red_q       <= 4'd0;
      green_q     <= 4'd0;
      blue_q      <= 4'd0;
      rgb_valid_q <= 1'b0;
    end else begin
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      rgb_valid_q <= pix_valid_i;
    end
  end

  assign pal_index_o = pix_index_i;
  assign red_o       = red_q;
  assign green_o     = green_q;
  assign blue_o      = blue_q;
  assign rgb_valid_o = rgb_valid_q;
  assign level_o     = level_q;
  assign busy_o      = (state_q == ST_FADE_OUT) || (state_q == ST_FADE_IN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Self-checking bench for palette_fade_ctrl: scoreboard on the RGB stream plus directed
// level/busy/done checks; a second instance exercises STEP=3 clamping.
module tb_palette_fade_ctrl;

`ifdef PALETTE_FADE_FLASH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pix_index;
  logic       pix_valid;
  logic       vsync;
  logic       fo, fi, flash;
  logic       fo3, fi3;

  logic [4:0] pal_index, pal_index3;
  logic [3:0] rom_r, rom_g, rom_b, rom3_r, rom3_g, rom3_b;
  logic [3:0] red, green, blue, red3, green3, blue3;
  logic       rgb_valid, rgb_valid3;
  logic [4:0] level, level3;
  logic       busy, busy3, done, done3;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  // Palette ROM model: entry 5 is {C,8,D}; other entries derive from the index.
  function automatic logic [11:0] rom(input logic [4:0] idx);
    if (idx == 5'd5) return 12'hC8D;
    return {idx[3:0], 4'h3, 4'h9};
  endfunction

  assign {rom_r, rom_g, rom_b}    = rom(pal_index);
  assign {rom3_r, rom3_g, rom3_b} = rom(pal_index3);

  palette_fade_ctrl #(.FRAMES_PER_STEP(2), .STEP(2), .FLASH_FRAMES(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .pix_index_i(pix_index), .pix_valid_i(pix_valid),
    .vsync_pulse_i(vsync), .fade_out_req_i(fo), .fade_in_req_i(fi), .flash_req_i(flash),
    .pal_index_o(pal_index), .pal_red_i(rom_r), .pal_green_i(rom_g), .pal_blue_i(rom_b),
    .red_o(red), .green_o(green), .blue_o(blue), .rgb_valid_o(rgb_valid),
    .level_o(level), .busy_o(busy), .done_o(done)
  );

  palette_fade_ctrl #(.FRAMES_PER_STEP(2), .STEP(3), .FLASH_FRAMES(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .pix_index_i(pix_index), .pix_valid_i(pix_valid),
    .vsync_pulse_i(vsync), .fade_out_req_i(fo3), .fade_in_req_i(fi3), .flash_req_i(1'b0),
    .pal_index_o(pal_index3), .pal_red_i(rom3_r), .pal_green_i(rom3_g), .pal_blue_i(rom3_b),
    .red_o(red3), .green_o(green3), .blue_o(blue3), .rgb_valid_o(rgb_valid3),
    .level_o(level3), .busy_o(busy3), .done_o(done3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; strobes and pix_valid drop back to idle right after the edge.
  task automatic clk_cycle();
    @(posedge clk);
    #1;
    vsync     = 1'b0;
    fo        = 1'b0;
    fi        = 1'b0;
    flash     = 1'b0;
    fo3       = 1'b0;
    fi3       = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic vs();
    vsync = 1'b1;
    clk_cycle();
  endtask

  task automatic pixel(input logic [4:0] idx, input logic [11:0] exp);
    pix_index = idx;
    pix_valid = 1'b1;
    #1;
    check("pal_index", pal_index, idx);
    sb_q.push_back(exp);
    clk_cycle();
  endtask

  // Monitor: every valid RGB beat must match the oldest queued expectation.
  initial begin
    logic [11:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && rgb_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_valid", rgb_valid, 1'b0);
        end else begin
          exp = sb_q.pop_front();
          check("sb_rgb", {red, green, blue}, exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    rst = 1'b1; pix_index = 5'd0; pix_valid = 1'b0; vsync = 1'b0;
    fo = 1'b0; fi = 1'b0; flash = 1'b0; fo3 = 1'b0; fi3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_level", level, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rgb_valid", rgb_valid, 1'b0);
    check("rst_rgb", {red, green, blue}, 12'h000);
    pixel(5'd5, 12'h000);

    // Fade in from DARK: +2 on every 2nd vsync.
    fi = 1'b1;
    clk_cycle();
    check("fi_busy", busy, 1'b1);
    check("fi_level0", level, 5'd0);
    for (int k = 1; k <= 16; k++) begin
      vs();
      check("fi_level", level, 32'((k / 2) * 2));
      check("fi_done", done, 32'(k == 16));
      if (k == 8) pixel(5'd5, 12'h646);
    end
    check("fi_busy_end", busy, 1'b0);
    clk_cycle();
    check("fi_done_single", done, 1'b0);
    pixel(5'd5, 12'hC8D);
    pixel(5'd10, 12'hA39);

    // Reversal mid fade-out: level continues upward with no dip.
    fo = 1'b1;
    clk_cycle();
    check("rev_busy", busy, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      vs();
      check("rev_out_level", level, 32'(16 - 2 * (j / 2)));
    end
    fi = 1'b1;
    clk_cycle();
    check("rev_hold_level", level, 5'd10);
    check("rev_hold_busy", busy, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      vs();
      check("rev_in_level", level, 32'(10 + 2 * (j / 2)));
      check("rev_in_done", done, 32'(j == 6));
    end
    check("rev_busy_end", busy, 1'b0);

    // Simultaneous requests from FULL: fade-out wins.
    fo = 1'b1;
    fi = 1'b1;
    clk_cycle();
    check("both_busy", busy, 1'b1);
    vs(); vs();
    check("both_dir_level", level, 5'd14);
    check("both_dir_done", done, 1'b0);
    fi = 1'b1;
    clk_cycle();
    vs(); vs();
    check("back_full_level", level, 5'd16);
    check("back_full_done", done, 1'b1);
    clk_cycle();
    check("back_full_busy", busy, 1'b0);

    // Non-reversing request and stray vsyncs in FULL are ignored.
    fi = 1'b1;
    clk_cycle();
    check("ign_busy", busy, 1'b0);
    check("ign_done", done, 1'b0);
    check("ign_level", level, 5'd16);
    vs(); vs();
    check("ign_vs_level", level, 5'd16);
    check("ign_vs_done", done, 1'b0);

    // STEP=3 instance: request on a step edge, then full in/out with clamping.
    fi3 = 1'b1;
    clk_cycle();
    check("s3_busy", busy3, 1'b1);
    vs();
    vsync = 1'b1;
    fo3   = 1'b1;
    clk_cycle();
    check("s3_stepreq_level", level3, 5'd3);
    check("s3_stepreq_busy", busy3, 1'b1);
    vs();
    check("s3_stepreq_hold", level3, 5'd3);
    vs();
    check("s3_dark_level", level3, 5'd0);
    check("s3_dark_done", done3, 1'b1);
    check("s3_dark_busy", busy3, 1'b0);
    fi3 = 1'b1;
    clk_cycle();
    for (int k = 1; k <= 12; k++) begin
      vs();
      e = 3 * (k / 2);
      if (e > 16) e = 16;
      check("s3_in_level", level3, 32'(e));
      check("s3_in_done", done3, 32'(k == 12));
    end
    fo3 = 1'b1;
    clk_cycle();
    for (int k = 1; k <= 12; k++) begin
      vs();
      e = 16 - 3 * (k / 2);
      if (e < 0) e = 0;
      check("s3_out_level", level3, 32'(e));
      check("s3_out_done", done3, 32'(k == 12));
      if (k == 6) begin
        pixel(5'd5, 12'hC8D);
        check("s3_rgb_l7", {red3, green3, blue3}, 12'h535);
        check("s3_rgb_valid", rgb_valid3, 1'b1);
      end
    end
    check("s3_out_busy", busy3, 1'b0);

    // Invalid pixel clears the output one cycle later.
    pixel(5'd5, 12'hC8D);
    pix_index = 5'd5;
    pix_valid = 1'b0;
    clk_cycle();
    check("inv_rgb_valid", rgb_valid, 1'b0);
    check("inv_rgb", {red, green, blue}, 12'h000);

    // Flash while fading out from level 8; the level keeps stepping underneath.
    fo = 1'b1;
    clk_cycle();
    repeat (8) vs();
    check("fl_level8", level, 5'd8);
    flash = 1'b1;
    clk_cycle();
    pixel(5'd5, FL ? 12'hFFF : 12'h646);
    vs();
    check("fl_level_a", level, 5'd8);
    pixel(5'd5, FL ? 12'hFFF : 12'h646);
    pix_index = 5'd5;
    pix_valid = 1'b0;
    clk_cycle();
    check("fl_inv_valid", rgb_valid, 1'b0);
    check("fl_inv_rgb", {red, green, blue}, 12'h000);
    vs(); vs();
    check("fl_level_b", level, 5'd6);
    pixel(5'd5, FL ? 12'hFFF : 12'h434);
    flash = 1'b1;
    clk_cycle();
    vs();
    check("fl_level_c", level, 5'd4);
    pixel(5'd5, FL ? 12'hFFF : 12'h323);
    vs(); vs();
    check("fl_level_d", level, 5'd2);
    pixel(5'd5, FL ? 12'hFFF : 12'h111);
    vs();
    check("fl_level_e", level, 5'd2);
    pixel(5'd5, 12'h111);
    vs();
    check("fl_end_level", level, 5'd0);
    check("fl_end_done", done, 1'b1);
    check("fl_end_busy", busy, 1'b0);

    // Asynchronous reset in the middle of a fade.
    fi = 1'b1;
    clk_cycle();
    vs(); vs();
    check("ar_pre_level", level, 5'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_level", level, 5'd0);
    check("ar_busy", busy, 1'b0);
    clk_cycle();
    rst = 1'b0;
    clk_cycle();
    check("ar_after_level", level, 5'd0);
    check("ar_after_busy", busy, 1'b0);

    repeat (3) clk_cycle();
    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/palette_fade_ctrl.md
Name: palette_fade_ctrl

Overview:
- Sequences brightness fades on the background palette path: forwards the renderer's 5-bit pixel index to the palette ROM and scales the returned 4-bit RGB by a frame-stepped brightness level.
- Sits between the background renderer and the VGA output register; used for level-start fade-in, death/level-end fade-out and, optionally, a full-screen white flash.

Parameters:
- FRAMES_PER_STEP, 2, vsync pulses between level updates (>=1)
- STEP, 2, level change per update (1..16)
- FLASH_FRAMES, 4, frames the white flash lasts (used only with PALETTE_FADE_FLASH_EN)

Ports:
- Clk  in  1  system/pixel clock
- Reset  in  1  asynchronous active-high reset
- pix_index  in  5  palette index from renderer
- pix_valid  in  1  index is an active-area pixel
- vsync_pulse  in  1  one-cycle strobe per frame
- fade_out_req  in  1  one-cycle request: fade to black
- fade_in_req  in  1  one-cycle request: fade to full
- flash_req  in  1  one-cycle request: white flash (ignored without macro)
- pal_index  out  5  index to palette ROM (combinational = pix_index)
- pal_red, pal_green, pal_blue  in  4 each  palette ROM output (combinational from pal_index)
- red, green, blue  out  4 each  scaled colour, registered
- rgb_valid  out  1  pix_valid delayed 1 cycle
- level  out  5  current brightness 0..16
- busy  out  1  high in FADE_OUT/FADE_IN
- done  out  1  one-cycle pulse when a fade reaches its endpoint

Behaviour:
- Reset (async): state=DARK, level=0, frame_cnt=0, red/green/blue=0, rgb_valid=0, done=0, flash counter=0.
- Datapath, 1-cycle latency: on each Clk, channel_out = (channel_in * level) >> 4 (4x5-bit product, 9 bits, keep bits [7:4]). Level 16 is identity; level 0 gives black. If pix_valid=0, register 0 on all channels. rgb_valid <= pix_valid. The level used is the value registered before that edge.
- FSM states: FULL (level=16), FADE_OUT, DARK (level=0), FADE_IN.
  - FULL: fade_out_req -> FADE_OUT. DARK: fade_in_req -> FADE_IN.
  - FADE_OUT: fade_in_req -> FADE_IN, level kept (reversal). FADE_IN: fade_out_req -> FADE_OUT, level kept.
  - Requests that do not change direction are ignored: fade_in in FULL/FADE_IN, fade_out in DARK/FADE_OUT.
  - Both requests in the same cycle: fade_out wins.
- Stepping: frame_cnt clears on every entry to a fade state. In a fade state, each vsync_pulse increments frame_cnt. On the pulse where frame_cnt==FRAMES_PER_STEP-1:
  - frame_cnt clears.
  - FADE_OUT: level = max(level-STEP, 0).
  - FADE_IN: level = min(level+STEP, 16).
- Endpoints: when level reaches 0 in FADE_OUT, go to DARK on that cycle with a 1-cycle done pulse. When level reaches 16 in FADE_IN, go to FULL with a 1-cycle done pulse.
- A request arriving in the same cycle as a step is applied after the step: the direction changes and frame_cnt clears.
- busy=1 exactly in FADE_OUT and FADE_IN (registered, from state).
- vsync_pulse outside fade states has no effect on level.
- Reset mid-fade returns to DARK, level 0, immediately.

Optional Feature:
- Macro PALETTE_FADE_FLASH_EN.
- Defined:
  - flash_req loads the flash counter with FLASH_FRAMES.
  - Each vsync_pulse decrements the counter while it is nonzero.
  - While the counter is nonzero, valid pixels output {F,F,F} regardless of level; invalid pixels still output 0.
  - The FSM and level continue independently.
  - flash_req while a flash is active reloads the counter.
- Undefined: flash_req is ignored, no flash counter is built, and the output is always the scaled palette colour.

Test Plan:
- Reset, then hold pix_valid=1 with a palette entry of {C,8,D} -> level=0, outputs {0,0,0}, busy=0, state DARK.
- fade_in_req with FRAMES_PER_STEP=2, STEP=2 -> level steps 2,4,...,16 on every 2nd vsync. At level 8 the output is {6,4,6}. done pulses once after 16 vsyncs, busy falls, output is {C,8,D}.
- From FULL, fade_out_req, wait 3 steps (level=10), then fade_in_req -> level rises 12,14,16 with no dip. done pulses once at 16.
- fade_out_req and fade_in_req in the same cycle from FULL -> FADE_OUT entered. fade_in_req in FULL alone -> no state change, done stays 0.
- STEP=3 fade_out from 16 -> levels 13,10,7,4,1,0 (clamped), then DARK with a done pulse. pix_valid=0 in any state -> output 0 and rgb_valid=0 one cycle later.
- With PALETTE_FADE_FLASH_EN at level 8: flash_req -> valid pixels {F,F,F} for exactly 4 vsync periods, then the scaled colour resumes. Without the macro, the same stimulus produces no change.
